// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the initiator and for future AHB slaves:
//   - HTRANS transfer-type codes
//   - HSIZE codes, fixed HBURST / HPROT values
//   - ahb_master FSM state encoding
//   - cmd_is_legal(): size / alignment check for a single transfer
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } master_state_t;

  // A transfer is legal only for byte/half/word sizes at a naturally
  // aligned address; anything else is rejected without touching the bus.
  function automatic logic cmd_is_legal(input logic [2:0] size,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_master_if.sv
// ---------------------------------------------------------------------------
// ahb_master_if
// AHB-Lite bus signals between one initiator and the interconnect.
//   master modport: drives HADDR_O/HTRANS_O/HWRITE_O/HSIZE_O/HBURST_O/
//                   HPROT_O/HWDATA_O, receives HRDATA_I/HREADY_I/HRESP_I
//   slave modport:  the mirror image
// ---------------------------------------------------------------------------
interface ahb_master_if;

  logic [31:0] HADDR_O;
  logic [1:0]  HTRANS_O;
  logic        HWRITE_O;
  logic [2:0]  HSIZE_O;
  logic [2:0]  HBURST_O;
  logic [3:0]  HPROT_O;
  logic [31:0] HWDATA_O;
  logic [31:0] HRDATA_I;
  logic        HREADY_I;
  logic        HRESP_I;

  modport master (
    output HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HWDATA_O,
    input  HRDATA_I, HREADY_I, HRESP_I
  );

  modport slave (
    input  HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HBURST_O, HPROT_O, HWDATA_O,
    output HRDATA_I, HREADY_I, HRESP_I
  );

endinterface

// File: rtl/ahb_lane_align.sv
// ---------------------------------------------------------------------------
// ahb_lane_align
// Combinational byte-lane steering for 32-bit AHB-Lite.
//   size          in  3   HSIZE code
//   addr_lo       in  2   address bits [1:0]
//   wdata         in  32  right-aligned write data
//   rdata         in  32  raw HRDATA bus
//   wdata_lanes   out 32  write data replicated onto every lane
//   rdata_aligned out 32  addressed lane(s), right-aligned, zero-extended
// ---------------------------------------------------------------------------
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Replicating write data means the slave can pick any lane without
  // knowing the size; word and unknown sizes pass straight through.
  always_comb begin
    wdata_lanes   = wdata;
    rdata_aligned = rdata;
    case (size)
      HSIZE_BYTE: begin
        wdata_lanes   = {4{wdata[7:0]}};
        rdata_aligned = {24'h0, byte_lane};
      end
      HSIZE_HALF: begin
        wdata_lanes   = {2{wdata[15:0]}};
        rdata_aligned = {16'h0, half_lane};
      end
      default: begin
        wdata_lanes   = wdata;
        rdata_aligned = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_master.sv
// ---------------------------------------------------------------------------
// ahb_master
// Single-transfer AHB-Lite initiator: one command in, one NONSEQ SINGLE
// transfer on the bus, one response out. At most one transfer outstanding.
//   HCLK_I, HRESET_N_I         clock, async active-low reset
//   CMD_VALID_I / CMD_READY_O  command handshake
//   CMD_WRITE_I, CMD_ADDR_I, CMD_SIZE_I, CMD_WDATA_I   command fields
//   RSP_VALID_O / RSP_READY_I  response handshake
//   RSP_RDATA_O, RSP_ERR_O     response fields
//   bus                        AHB-Lite master modport
// ---------------------------------------------------------------------------
module ahb_master
  import ahb_pkg::*;
(
  input  logic         HCLK_I,
  input  logic         HRESET_N_I,
  input  logic         CMD_VALID_I,
  output logic         CMD_READY_O,
  input  logic         CMD_WRITE_I,
  input  logic [31:0]  CMD_ADDR_I,
  input  logic [2:0]   CMD_SIZE_I,
  input  logic [31:0]  CMD_WDATA_I,
  output logic         RSP_VALID_O,
  input  logic         RSP_READY_I,
  output logic [31:0]  RSP_RDATA_O,
  output logic         RSP_ERR_O,
  ahb_master_if.master bus
);

  master_state_t state_q, state_d;
  htrans_t       htrans_q, htrans_d;
  logic [31:0]   haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [2:0]    align_size;
  logic [1:0]    align_addr;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_aligned;

  // One aligner serves both directions: while idle it steers the incoming
  // write data, afterwards it extracts read data for the latched transfer.
  assign align_size = (state_q == ST_IDLE) ? CMD_SIZE_I      : hsize_q;
  assign align_addr = (state_q == ST_IDLE) ? CMD_ADDR_I[1:0] : haddr_q[1:0];

  ahb_lane_align u_align (
    .size          (align_size),
    .addr_lo       (align_addr),
    .wdata         (CMD_WDATA_I),
    .rdata         (bus.HRDATA_I),
    .wdata_lanes   (wdata_lanes),
    .rdata_aligned (rdata_aligned)
  );

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID_I) begin
          if (cmd_is_legal(CMD_SIZE_I, CMD_ADDR_I[1:0])) begin
            haddr_d     = CMD_ADDR_I;
            hwrite_d    = CMD_WRITE_I;
            hsize_d     = CMD_SIZE_I;
            hwdata_d    = CMD_WRITE_I ? wdata_lanes : 32'h0;
            htrans_d    = HTRANS_NONSEQ;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
            state_d     = ST_ADDR;
          end else begin
            // Rejected command: answer immediately, bus stays idle.
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (bus.HREADY_I) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        // The first ERROR cycle has HREADY low and simply extends the wait.
        if (bus.HREADY_I) begin
          rsp_err_d   = bus.HRESP_I;
          rsp_rdata_d = (hwrite_q || bus.HRESP_I) ? 32'h0 : rdata_aligned;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RSP_READY_I) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
    if (!HRESET_N_I) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'h0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign CMD_READY_O  = (state_q == ST_IDLE);
  assign RSP_VALID_O  = rsp_valid_q;
  assign RSP_RDATA_O  = rsp_rdata_q;
  assign RSP_ERR_O    = rsp_err_q;
  assign bus.HADDR_O  = haddr_q;
  assign bus.HTRANS_O = htrans_q;
  assign bus.HWRITE_O = hwrite_q;
  assign bus.HSIZE_O  = hsize_q;
  assign bus.HBURST_O = HBURST_SINGLE;
  assign bus.HPROT_O  = HPROT_DEFAULT;
  assign bus.HWDATA_O = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_master
// Self-checking bench for ahb_master. Each transfer's expected bus activity,
// latency and response are worked out up front from the transfer rules
// (alignment by modulo, lane handling by multiply/shift/mask, phase lengths
// from wait counts) and compared cycle by cycle against the DUT.
// ---------------------------------------------------------------------------
module tb_ahb_master;

  logic        HCLK_I;
  logic        HRESET_N_I;
  logic        CMD_VALID_I;
  logic        CMD_READY_O;
  logic        CMD_WRITE_I;
  logic [31:0] CMD_ADDR_I;
  logic [2:0]  CMD_SIZE_I;
  logic [31:0] CMD_WDATA_I;
  logic        RSP_VALID_O;
  logic        RSP_READY_I;
  logic [31:0] RSP_RDATA_O;
  logic        RSP_ERR_O;

  ahb_master_if bus_if ();

  int n_checks = 0;
  int n_fail   = 0;

  ahb_master dut (
    .HCLK_I      (HCLK_I),
    .HRESET_N_I  (HRESET_N_I),
    .CMD_VALID_I (CMD_VALID_I),
    .CMD_READY_O (CMD_READY_O),
    .CMD_WRITE_I (CMD_WRITE_I),
    .CMD_ADDR_I  (CMD_ADDR_I),
    .CMD_SIZE_I  (CMD_SIZE_I),
    .CMD_WDATA_I (CMD_WDATA_I),
    .RSP_VALID_O (RSP_VALID_O),
    .RSP_READY_I (RSP_READY_I),
    .RSP_RDATA_O (RSP_RDATA_O),
    .RSP_ERR_O   (RSP_ERR_O),
    .bus         (bus_if)
  );

  initial begin
    HCLK_I = 1'b0;
    forever #5 HCLK_I = ~HCLK_I;
  end

  task automatic test_reset();
    HRESET_N_I = 1'b1;
    CMD_VALID_I = 1'b0; CMD_WRITE_I = 1'b0; CMD_ADDR_I = '0;
    CMD_SIZE_I = '0; CMD_WDATA_I = '0; RSP_READY_I = 1'b0;
    bus_if.HRDATA_I = '0; bus_if.HREADY_I = 1'b1; bus_if.HRESP_I = 1'b0;
    #2 HRESET_N_I = 1'b0;
    @(negedge HCLK_I);
    @(negedge HCLK_I);
    n_checks++; if (CMD_READY_O !== 1'b1) begin n_fail++; $display("[TB] FAIL reset cmd_ready got %b expected 1", CMD_READY_O); end
    n_checks++; if (RSP_VALID_O !== 1'b0) begin n_fail++; $display("[TB] FAIL reset rsp_valid got %b expected 0", RSP_VALID_O); end
    n_checks++; if (RSP_RDATA_O !== 32'h0) begin n_fail++; $display("[TB] FAIL reset rsp_rdata got %h expected 0", RSP_RDATA_O); end
    n_checks++; if (RSP_ERR_O !== 1'b0) begin n_fail++; $display("[TB] FAIL reset rsp_err got %b expected 0", RSP_ERR_O); end
    n_checks++; if (bus_if.HTRANS_O !== 2'b00) begin n_fail++; $display("[TB] FAIL reset htrans got %b expected 00", bus_if.HTRANS_O); end
    n_checks++; if (bus_if.HADDR_O !== 32'h0) begin n_fail++; $display("[TB] FAIL reset haddr got %h expected 0", bus_if.HADDR_O); end
    n_checks++; if (bus_if.HWRITE_O !== 1'b0) begin n_fail++; $display("[TB] FAIL reset hwrite got %b expected 0", bus_if.HWRITE_O); end
    n_checks++; if (bus_if.HSIZE_O !== 3'h0) begin n_fail++; $display("[TB] FAIL reset hsize got %h expected 0", bus_if.HSIZE_O); end
    n_checks++; if (bus_if.HWDATA_O !== 32'h0) begin n_fail++; $display("[TB] FAIL reset hwdata got %h expected 0", bus_if.HWDATA_O); end
    n_checks++; if (bus_if.HBURST_O !== 3'b000) begin n_fail++; $display("[TB] FAIL reset hburst got %b expected 000", bus_if.HBURST_O); end
    n_checks++; if (bus_if.HPROT_O !== 4'b0011) begin n_fail++; $display("[TB] FAIL reset hprot got %b expected 0011", bus_if.HPROT_O); end
    HRESET_N_I = 1'b1;
  endtask

  // Starts and ends at a falling clock edge. aw/dw are wait states in the
  // address/data phase; err requests a two-cycle slave ERROR after dw waits.
  task automatic run_transfer(input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int aw, input int dw,
                              input bit err, input int hold, input string name);
    bit          legal;
    logic [31:0] exp_wd, exp_rd, lane;
    logic        exp_err;
    int          dwe, addr_last, data_first, resp_cyc, k;
    logic [1:0]  exp_trans;
    bit          in_data;

    legal = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0);
    case (size)
      3'd0:    exp_wd = {24'h0, wdata[7:0]} * 32'h01010101;
      3'd1:    exp_wd = {16'h0, wdata[15:0]} * 32'h00010001;
      default: exp_wd = wdata;
    endcase
    case (size)
      3'd0:    lane = (rdata >> (8 * addr[1:0])) & 32'h000000FF;
      3'd1:    lane = (rdata >> (16 * addr[1])) & 32'h0000FFFF;
      default: lane = rdata;
    endcase
    exp_err    = !legal || err;
    exp_rd     = (!legal || wr || err) ? 32'h0 : lane;
    dwe        = err ? dw + 1 : dw;
    addr_last  = 1 + aw;
    data_first = 2 + aw;
    resp_cyc   = legal ? 3 + aw + dwe : 1;

    CMD_VALID_I = 1'b1; CMD_WRITE_I = wr; CMD_ADDR_I = addr;
    CMD_SIZE_I = size; CMD_WDATA_I = wdata; RSP_READY_I = 1'b0;
    n_checks++; if (CMD_READY_O !== 1'b1) begin n_fail++; $display("[TB] FAIL %s cmd_ready at offer got %b expected 1", name, CMD_READY_O); end
    @(posedge HCLK_I); #1;
    CMD_VALID_I = 1'b0; CMD_WRITE_I = $urandom; CMD_ADDR_I = $urandom;
    CMD_SIZE_I = 3'($urandom); CMD_WDATA_I = $urandom;

    for (int cyc = 1; cyc < resp_cyc; cyc++) begin
      in_data = legal && (cyc >= data_first);
      bus_if.HRDATA_I = $urandom;
      bus_if.HRESP_I  = 1'b0;
      if (!in_data) begin
        bus_if.HREADY_I = (cyc == addr_last);
        exp_trans = legal ? 2'b10 : 2'b00;
      end else begin
        k = cyc - data_first;
        exp_trans = 2'b00;
        bus_if.HREADY_I = (k == dwe);
        if (err && k >= dw) bus_if.HRESP_I = 1'b1;
        if (k == dwe) bus_if.HRDATA_I = rdata;
      end
      @(negedge HCLK_I);
      n_checks++; if (bus_if.HTRANS_O !== exp_trans) begin n_fail++; $display("[TB] FAIL %s htrans cyc%0d got %b expected %b", name, cyc, bus_if.HTRANS_O, exp_trans); end
      n_checks++; if (RSP_VALID_O !== 1'b0) begin n_fail++; $display("[TB] FAIL %s rsp_valid early cyc%0d got %b expected 0", name, cyc, RSP_VALID_O); end
      n_checks++; if (CMD_READY_O !== 1'b0) begin n_fail++; $display("[TB] FAIL %s cmd_ready busy cyc%0d got %b expected 0", name, cyc, CMD_READY_O); end
      if (cyc == 1) begin
        n_checks++; if (bus_if.HADDR_O !== addr) begin n_fail++; $display("[TB] FAIL %s haddr got %h expected %h", name, bus_if.HADDR_O, addr); end
        n_checks++; if (bus_if.HWRITE_O !== wr) begin n_fail++; $display("[TB] FAIL %s hwrite got %b expected %b", name, bus_if.HWRITE_O, wr); end
        n_checks++; if (bus_if.HSIZE_O !== size) begin n_fail++; $display("[TB] FAIL %s hsize got %h expected %h", name, bus_if.HSIZE_O, size); end
        n_checks++; if (bus_if.HBURST_O !== 3'b000) begin n_fail++; $display("[TB] FAIL %s hburst got %b expected 000", name, bus_if.HBURST_O); end
      end
      if (in_data && wr) begin
        n_checks++; if (bus_if.HWDATA_O !== exp_wd) begin n_fail++; $display("[TB] FAIL %s hwdata cyc%0d got %h expected %h", name, cyc, bus_if.HWDATA_O, exp_wd); end
      end
      @(posedge HCLK_I); #1;
    end

    for (int h = 0; h <= hold; h++) begin
      bus_if.HRDATA_I = $urandom; bus_if.HREADY_I = $urandom; bus_if.HRESP_I = $urandom;
      @(negedge HCLK_I);
      n_checks++; if (RSP_VALID_O !== 1'b1) begin n_fail++; $display("[TB] FAIL %s rsp_valid hold%0d got %b expected 1", name, h, RSP_VALID_O); end
      n_checks++; if (RSP_RDATA_O !== exp_rd) begin n_fail++; $display("[TB] FAIL %s rsp_rdata hold%0d got %h expected %h", name, h, RSP_RDATA_O, exp_rd); end
      n_checks++; if (RSP_ERR_O !== exp_err) begin n_fail++; $display("[TB] FAIL %s rsp_err hold%0d got %b expected %b", name, h, RSP_ERR_O, exp_err); end
      n_checks++; if (CMD_READY_O !== 1'b0) begin n_fail++; $display("[TB] FAIL %s cmd_ready in resp hold%0d got %b expected 0", name, h, CMD_READY_O); end
      n_checks++; if (bus_if.HTRANS_O !== 2'b00) begin n_fail++; $display("[TB] FAIL %s htrans in resp hold%0d got %b expected 00", name, h, bus_if.HTRANS_O); end
      if (h == hold) RSP_READY_I = 1'b1;
      @(posedge HCLK_I); #1;
    end
    RSP_READY_I = 1'b0;
    bus_if.HREADY_I = 1'b1; bus_if.HRESP_I = 1'b0;
    @(negedge HCLK_I);
    n_checks++; if (CMD_READY_O !== 1'b1) begin n_fail++; $display("[TB] FAIL %s cmd_ready after handshake got %b expected 1", name, CMD_READY_O); end
    n_checks++; if (RSP_VALID_O !== 1'b0) begin n_fail++; $display("[TB] FAIL %s rsp_valid after handshake got %b expected 0", name, RSP_VALID_O); end
  endtask

  task automatic test_directed();
    run_transfer(1'b1, 32'h0000_0004, 3'd2, 32'h12345678, 32'h0, 0, 0, 1'b0, 0, "word_write");
    run_transfer(1'b0, 32'h0000_0003, 3'd0, 32'h0, 32'hAABBCCDD, 0, 2, 1'b0, 0, "byte_read_waits");
    run_transfer(1'b1, 32'h0000_0002, 3'd1, 32'h0000BEEF, 32'h0, 0, 0, 1'b0, 0, "half_write");
    run_transfer(1'b0, 32'h0000_0010, 3'd2, 32'h0, 32'hDEADBEEF, 1, 0, 1'b1, 0, "slave_error_read");
    run_transfer(1'b0, 32'h0000_0002, 3'd2, 32'h0, 32'h11223344, 0, 0, 1'b0, 1, "misaligned_word");
    run_transfer(1'b1, 32'h0000_0008, 3'd3, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0, 0, "size3_reject");
    run_transfer(1'b0, 32'h0000_0022, 3'd1, 32'h0, 32'h5566_7788, 2, 1, 1'b0, 10, "resp_hold10");
  endtask

  task automatic test_back_to_back();
    run_transfer(1'b0, 32'h0000_0101, 3'd0, 32'h0, 32'h01020304, 0, 0, 1'b0, 0, "b2b_first");
    run_transfer(1'b1, 32'h0000_0105, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 0, "b2b_reject");
    run_transfer(1'b1, 32'h0000_0107, 3'd0, 32'h000000A5, 32'h0, 0, 0, 1'b0, 0, "b2b_third");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  size;
    for (int i = 0; i < 40; i++) begin
      size = 3'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_transfer(1'($urandom), addr, size, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_in_data();
    CMD_VALID_I = 1'b1; CMD_WRITE_I = 1'b1; CMD_ADDR_I = 32'h0000_0040;
    CMD_SIZE_I = 3'd2; CMD_WDATA_I = 32'h87654321;
    @(posedge HCLK_I); #1;
    CMD_VALID_I = 1'b0; bus_if.HREADY_I = 1'b1;
    @(negedge HCLK_I);
    n_checks++; if (bus_if.HTRANS_O !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_data nonseq got %b expected 10", bus_if.HTRANS_O); end
    @(posedge HCLK_I); #1;
    bus_if.HREADY_I = 1'b0;
    @(negedge HCLK_I);
    n_checks++; if (CMD_READY_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data busy cmd_ready got %b expected 0", CMD_READY_O); end
    #1 HRESET_N_I = 1'b0;
    #1;
    n_checks++; if (bus_if.HTRANS_O !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_data htrans got %b expected 00", bus_if.HTRANS_O); end
    n_checks++; if (RSP_VALID_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data rsp_valid got %b expected 0", RSP_VALID_O); end
    n_checks++; if (CMD_READY_O !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_data cmd_ready got %b expected 1", CMD_READY_O); end
    n_checks++; if (bus_if.HADDR_O !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_data haddr got %h expected 0", bus_if.HADDR_O); end
    n_checks++; if (bus_if.HWDATA_O !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_data hwdata got %h expected 0", bus_if.HWDATA_O); end
    n_checks++; if (bus_if.HWRITE_O !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_data hwrite got %b expected 0", bus_if.HWRITE_O); end
    @(negedge HCLK_I);
    HRESET_N_I = 1'b1;
    bus_if.HREADY_I = 1'b1;
    run_transfer(1'b0, 32'h0000_0100, 3'd2, 32'h0, 32'h0BADF00D, 0, 1, 1'b0, 0, "after_reset_read");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
